// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: sequences one MEM-stage load/store over an SRAM-like
// request/response bus (addr_ok/data_ok). It decodes the op, forms the size,
// byte strobes and replicated store data, flags misaligned accesses, holds
// the MEM stage until the response is back and returns the extended load data.
module data_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_valid,
  input  logic [3:0]        ms_mem_op,
  input  logic [ADDR_W-1:0] ms_addr,
  input  logic [DATA_W-1:0] ms_wdata,
  input  logic              wb_allow_in,
  input  logic              flush,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ale_ex,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata
);

  localparam logic [3:0] OP_LD_B  = 4'b0001;
  localparam logic [3:0] OP_LD_H  = 4'b0010;
  localparam logic [3:0] OP_LD_W  = 4'b0011;
  localparam logic [3:0] OP_LD_BU = 4'b1001;
  localparam logic [3:0] OP_LD_HU = 4'b1010;
  localparam logic [3:0] OP_ST_B  = 4'b0100;
  localparam logic [3:0] OP_ST_H  = 4'b0101;
  localparam logic [3:0] OP_ST_W  = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LD_B) || (op == OP_LD_H) || (op == OP_LD_W) ||
           (op == OP_LD_BU) || (op == OP_LD_HU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_ST_B) || (op == OP_ST_H) || (op == OP_ST_W);
  endfunction

  // 0 = byte, 1 = half, 2 = word; undefined ops report byte and are never issued
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LD_H, OP_LD_HU, OP_ST_H: return 2'd1;
      OP_LD_W, OP_ST_W:           return 2'd2;
      default:                    return 2'd0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
    case (op_size(op))
      2'd1:    return lane[0];
      2'd2:    return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] st_strb(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      OP_ST_B: return 4'b0001 << lane;
      OP_ST_H: return lane[1] ? 4'b1100 : 4'b0011;
      OP_ST_W: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Narrow stores are replicated across every lane so the strobes alone pick the target bytes
  function automatic logic [DATA_W-1:0] st_wdata(input logic [3:0] op, input logic [DATA_W-1:0] d);
    case (op)
      OP_ST_B: return {4{d[7:0]}};
      OP_ST_H: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] ld_extend(input logic [3:0] op, input logic [1:0] lane,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0]        shifted;
    logic signed [7:0]        byte_s;
    logic signed [15:0]       half_s;
    logic signed [DATA_W-1:0] ext;
    shifted = d >> {lane, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (op)
      OP_LD_B:  ext = DATA_W'(byte_s);
      OP_LD_H:  ext = DATA_W'(half_s);
      OP_LD_BU: ext = DATA_W'(shifted[7:0]);
      OP_LD_HU: ext = DATA_W'(shifted[15:0]);
      OP_LD_W:  ext = d;
      default:  ext = '0;
    endcase
    return ext;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic ms_is_mem;
  logic ms_misaligned;
  logic start;

  assign ms_is_mem     = op_is_load(ms_mem_op) || op_is_store(ms_mem_op);
  assign ms_misaligned = op_misaligned(ms_mem_op, ms_addr[1:0]);
  assign start         = ms_valid && ms_is_mem && !ms_misaligned && !flush;
  assign ale_ex        = ms_valid && ms_is_mem && ms_misaligned;

  // Bus fields come only from the latched copy so they stay put while waiting for addr_ok
  assign data_sram_wr    = op_is_store(op_q);
  assign data_sram_size  = op_size(op_q);
  assign data_sram_wstrb = st_strb(op_q, addr_q[1:0]);
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = st_wdata(op_q, wdata_q);
  assign mem_rdata       = rdata_q;

  // Next-state, latch enables and the handshake outputs
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    mem_done      = 1'b0;
    data_sram_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = ms_mem_op;
          addr_d  = ms_addr;
          wdata_d = ms_wdata;
          state_d = S_REQ;
        end else begin
          // Nothing to send on the bus: non-memory ops and ALE victims pass straight through
          mem_done = ms_valid && (!ms_is_mem || ms_misaligned);
        end
      end
      S_REQ: begin
        data_sram_req = 1'b1;
        if (data_sram_addr_ok) begin
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = ld_extend(op_q, addr_q[1:0], data_sram_rdata);
            state_d = S_DONE;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        mem_done = 1'b1;
        if (flush || wb_allow_in) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // The accepted request still owes a response; swallow it before issuing anything new
        if (data_sram_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
